rotating_pattern: RTL and testbench
===================================

Name: rotating_pattern

Overview:
Parametrised animation engine for the board's active-low 7-segment bank. It generalises the single rotating square to:
- any digit count;
- a run-time step period;
- three animation modes: square, perimeter chase, bounce.

Only one digit is lit at a time, so no scan multiplexing is needed. It sits directly between the top-level enable/direction switches and the CA/AN pins.

Parameters:
- N_DIGITS, 8, number of digits driven; legal range 2 and up.
- DIV_W, 25, width of the step prescaler and of the period port.
- POS_W, $clog2(2*N_DIGITS+4), position register width; derived, do not override.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- en  in  1  1 = animate; 0 = freeze position and prescaler
- cw  in  1  1 = clockwise (position increments); 0 = counter-clockwise
- mode  in  2  0 square, 1 chase, 2 bounce, 3 blank
- period  in  DIV_W  one step every period+1 clocks
- CA  out  7  segment cathodes, active-low, bit0=a … bit6=g
- AN  out  N_DIGITS  digit anodes, active-low, bit0 = rightmost digit
- pos  out  POS_W  current position, for debug/verification

Behaviour:
- Clock and reset: one clock (clk); reset rst is synchronous, active-high.
- Reset values: pos=0, dir=up, cnt=0, mode_q=mode input; CA=7'h7F, AN=all 1s (blank).
- Prescaler:
  - tick = en && (cnt >= period).
  - On tick, cnt <= 0; else if en, cnt++; else cnt holds.
  - period=0 gives a step every clock.
  - Lowering period below cnt gives a tick on the next en cycle.
- Mode change: if mode != mode_q then pos <= 0, dir <= up, cnt <= 0, mode_q <= mode. This takes priority over tick, and no step occurs that cycle.
- Mode 0, square, length L=2N:
  - p<N: upper square (a,b,f,g; CA=7'b0011100) on digit N-1-p.
  - p>=N: lower square (c,d,e,g; CA=7'b0100011) on digit p-N.
  - Tick: cw=1 gives p = (p+1) mod L; cw=0 gives p = (p-1) mod L (0 wraps to L-1).
- Mode 1, chase, length L=2N+4, single segment:
  - p<N: seg a on digit N-1-p.
  - p=N: seg b on digit 0.
  - p=N+1: seg c on digit 0.
  - N+2 <= p < 2N+2: seg d on digit p-N-2.
  - p=2N+2: seg e on digit N-1.
  - p=2N+3: seg f on digit N-1.
  - Wrap rules are the same as mode 0.
- Mode 2, bounce:
  - Upper square only, on digit N-1-p, with p in 0..N-1; cw is ignored.
  - Tick with dir=up: p++. At p=N-1, set dir=down and p=N-2 in the same tick (no dwell).
  - Mirror rule at p=0: set dir=up and p=1.
- Mode 3: pos held at 0, outputs blank.
- Direction change mid-run: cw is sampled at each tick; the walk continues from the current pos, with no reset.
- Output timing:
  - CA and AN are registered, decoded from pos/mode_q, one cycle after pos changes.
  - pos output is the register itself (zero latency).
  - Exactly one AN bit is low except when blank.
- Reset mid-operation: at the next edge, all state returns to reset values. The first valid pattern appears one cycle after rst deasserts.

Decomposition:
- Package rotating_pkg holds:
  - mode_e enum (MODE_SQUARE, MODE_CHASE, MODE_BOUNCE, MODE_BLANK);
  - 7-bit active-low constants SEG_UPPER, SEG_LOWER, SEG_A..SEG_F, SEG_BLANK.
- Sub-module step_tick: the DIV_W prescaler, with clk, rst, en, period and a tick output, plus a clear input used on mode change.
- Position/direction FSM and output decode stay in rotating_pattern.

Test Plan (N_DIGITS=8):
1. Reset: rst=1 for 2 clocks -> CA=7'h7F, AN=8'hFF. Release with mode=0, en=0 -> one clock later pos=0, AN=8'h7F, CA=7'b0011100.
2. Square, cw=1, period=0, en=1 -> pos steps 0,1,…,15,0 on consecutive clocks. At pos=8 (next cycle): AN=8'hFE, CA=7'b0100011. At pos=15: AN=8'h7F, lower square.
3. Square, cw=0 from reset -> first tick gives pos=15, AN=8'h7F, CA=7'b0100011. Toggle cw to 1 at pos=12 -> next tick gives pos=13.
4. Chase, period=2 -> one step every 3 clocks; pos=8 gives CA=7'b1111101, AN=8'hFE; pos=19 gives CA=7'b1011111, AN=8'h7F; wraps 19->0.
5. Bounce, period=0 -> pos 0..7, then 6,5,…,0, then 1. Hold en=0 for 4 clocks at pos=5 -> pos and cnt frozen; resume at 5 in the same direction.
6. Switch mode 0->1 at pos=9 -> next clock pos=0 and no step; outputs show seg a on digit 7. Assert rst at pos=4 -> blank outputs and pos=0 at the next edge.

Source files
------------

// File: rtl/rotating_pattern_pkg.sv
// ============================================================================
// rotating_pkg : mode/direction enums and active-low segment constants
// Rev 1.0
// ============================================================================
`default_nettype none

package rotating_pkg;

  typedef enum logic [1:0] {
    MODE_SQUARE = 2'd0,
    MODE_CHASE  = 2'd1,
    MODE_BOUNCE = 2'd2,
    MODE_BLANK  = 2'd3
  } mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  // Cathodes are active-low, bit0 = a ... bit6 = g
  localparam logic [6:0] SEG_UPPER = 7'b0011100;
  localparam logic [6:0] SEG_LOWER = 7'b0100011;
  localparam logic [6:0] SEG_A     = 7'b1111110;
  localparam logic [6:0] SEG_B     = 7'b1111101;
  localparam logic [6:0] SEG_C     = 7'b1111011;
  localparam logic [6:0] SEG_D     = 7'b1110111;
  localparam logic [6:0] SEG_E     = 7'b1101111;
  localparam logic [6:0] SEG_F     = 7'b1011111;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

endpackage

`default_nettype wire

// File: rtl/rotating_pattern_step_tick.sv
// ============================================================================
// step_tick : run-time programmable step prescaler with synchronous clear
// Rev 1.0
// ============================================================================
`default_nettype none

module step_tick #(
  parameter int DIV_W = 25
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clear,
  input  logic [DIV_W-1:0] period,
  output logic             tick
);

  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] cnt_d;

  // >= rather than == so that shrinking period below cnt ticks immediately
  assign tick = en && (cnt_q >= period);

  always_comb begin
    cnt_d = cnt_q;
    if (clear || tick) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + DIV_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/rotating_pattern.sv
// ============================================================================
// rotating_pattern : single-digit animation engine for an active-low 7-seg bank
// Rev 1.0
// ============================================================================
`default_nettype none

module rotating_pattern
  import rotating_pkg::*;
#(
  parameter int N_DIGITS = 8,
  parameter int DIV_W    = 25,
  parameter int POS_W    = $clog2(2*N_DIGITS+4)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                cw,
  input  logic [1:0]          mode,
  input  logic [DIV_W-1:0]    period,
  output logic [6:0]          CA,
  output logic [N_DIGITS-1:0] AN,
  output logic [POS_W-1:0]    pos
);

  localparam logic [POS_W-1:0] LAST_DIG = POS_W'(N_DIGITS - 1);
  localparam logic [POS_W-1:0] NPOS     = POS_W'(N_DIGITS);
  localparam logic [POS_W-1:0] SQ_LAST  = POS_W'(2*N_DIGITS - 1);
  localparam logic [POS_W-1:0] CH_LAST  = POS_W'(2*N_DIGITS + 3);
  localparam logic [POS_W-1:0] CH_B     = POS_W'(N_DIGITS);
  localparam logic [POS_W-1:0] CH_C     = POS_W'(N_DIGITS + 1);
  localparam logic [POS_W-1:0] CH_D0    = POS_W'(N_DIGITS + 2);
  localparam logic [POS_W-1:0] CH_E     = POS_W'(2*N_DIGITS + 2);
  localparam logic [N_DIGITS-1:0] AN_ONE = N_DIGITS'(1);

  mode_e               mode_in;
  mode_e               mode_q, mode_d;
  dir_e                dir_q, dir_d;
  logic [POS_W-1:0]    pos_q, pos_d;
  logic [6:0]          ca_q, ca_d;
  logic [N_DIGITS-1:0] an_q, an_d;

  logic                mode_chg;
  logic                tick;
  logic [POS_W-1:0]    pos_inc;
  logic [POS_W-1:0]    pos_dec;
  logic [POS_W-1:0]    loop_last;
  logic [POS_W-1:0]    loop_next;
  logic [POS_W-1:0]    dig;
  logic                lit;

  assign mode_in  = mode_e'(mode);
  assign mode_chg = (mode_in != mode_q);

  step_tick #(
    .DIV_W (DIV_W)
  ) u_step_tick (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .clear  (mode_chg),
    .period (period),
    .tick   (tick)
  );

  // Square and chase share the same cyclic walk, only the loop length differs
  assign pos_inc   = pos_q + POS_W'(1);
  assign pos_dec   = pos_q - POS_W'(1);
  assign loop_last = (mode_q == MODE_CHASE) ? CH_LAST : SQ_LAST;

  always_comb begin
    loop_next = pos_dec;
    if (cw) begin
      loop_next = (pos_q == loop_last) ? '0 : pos_inc;
    end else if (pos_q == '0) begin
      loop_next = loop_last;
    end
  end

  always_comb begin
    pos_d  = pos_q;
    dir_d  = dir_q;
    mode_d = mode_q;
    if (mode_chg) begin
      pos_d  = '0;
      dir_d  = DIR_UP;
      mode_d = mode_in;
    end else if (tick) begin
      case (mode_q)
        MODE_SQUARE, MODE_CHASE: pos_d = loop_next;
        MODE_BOUNCE: begin
          // Turn around at either end without dwelling on the end digit
          if (dir_q == DIR_UP) begin
            if (pos_q == LAST_DIG) begin
              pos_d = LAST_DIG - POS_W'(1);
              dir_d = DIR_DOWN;
            end else begin
              pos_d = pos_inc;
            end
          end else begin
            if (pos_q == '0) begin
              pos_d = POS_W'(1);
              dir_d = DIR_UP;
            end else begin
              pos_d = pos_dec;
            end
          end
        end
        default: pos_d = '0;
      endcase
    end
  end

  always_comb begin
    ca_d = SEG_BLANK;
    dig  = '0;
    lit  = 1'b0;
    case (mode_q)
      MODE_SQUARE: begin
        lit = 1'b1;
        if (pos_q < NPOS) begin
          dig  = LAST_DIG - pos_q;
          ca_d = SEG_UPPER;
        end else begin
          dig  = pos_q - NPOS;
          ca_d = SEG_LOWER;
        end
      end
      MODE_CHASE: begin
        lit = 1'b1;
        if (pos_q < NPOS) begin
          dig  = LAST_DIG - pos_q;
          ca_d = SEG_A;
        end else if (pos_q == CH_B) begin
          ca_d = SEG_B;
        end else if (pos_q == CH_C) begin
          ca_d = SEG_C;
        end else if (pos_q < CH_E) begin
          dig  = pos_q - CH_D0;
          ca_d = SEG_D;
        end else if (pos_q == CH_E) begin
          dig  = LAST_DIG;
          ca_d = SEG_E;
        end else begin
          dig  = LAST_DIG;
          ca_d = SEG_F;
        end
      end
      MODE_BOUNCE: begin
        lit  = 1'b1;
        dig  = LAST_DIG - pos_q;
        ca_d = SEG_UPPER;
      end
      default: begin
        lit  = 1'b0;
        ca_d = SEG_BLANK;
      end
    endcase
    an_d = lit ? ~(AN_ONE << dig) : '1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pos_q  <= '0;
      dir_q  <= DIR_UP;
      mode_q <= mode_in;
      ca_q   <= SEG_BLANK;
      an_q   <= '1;
    end else begin
      pos_q  <= pos_d;
      dir_q  <= dir_d;
      mode_q <= mode_d;
      ca_q   <= ca_d;
      an_q   <= an_d;
    end
  end

  assign CA  = ca_q;
  assign AN  = an_q;
  assign pos = pos_q;

endmodule

`default_nettype wire

// File: tb/tb_rotating_pattern.sv
// ============================================================================
// tb_rotating_pattern : directed + randomized bench against a behavioural model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_rotating_pattern;

  localparam int N     = 8;
  localparam int DIV_W = 25;
  localparam int POS_W = $clog2(2*N+4);

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic             cw;
  logic [1:0]       mode;
  logic [DIV_W-1:0] period;
  logic [6:0]       CA;
  logic [N-1:0]     AN;
  logic [POS_W-1:0] pos;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int           m_pos, m_dir, m_cnt, m_mode;
  logic [6:0]   e_ca;
  logic [N-1:0] e_an;

  rotating_pattern #(
    .N_DIGITS (N),
    .DIV_W    (DIV_W)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .cw     (cw),
    .mode   (mode),
    .period (period),
    .CA     (CA),
    .AN     (AN),
    .pos    (pos)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Which digit/segments light for a given mode and position
  task automatic pattern(input int md, input int p, output logic [6:0] ca, output logic [N-1:0] an);
    int dig;
    dig = -1;
    ca  = 7'h7F;
    case (md)
      0: begin
        if (p < N) begin
          dig = N-1-p; ca[0] = 0; ca[1] = 0; ca[5] = 0; ca[6] = 0;
        end else begin
          dig = p-N;   ca[2] = 0; ca[3] = 0; ca[4] = 0; ca[6] = 0;
        end
      end
      1: begin
        if (p < N)            begin dig = N-1-p; ca[0] = 0; end
        else if (p == N)      begin dig = 0;     ca[1] = 0; end
        else if (p == N+1)    begin dig = 0;     ca[2] = 0; end
        else if (p < 2*N+2)   begin dig = p-N-2; ca[3] = 0; end
        else if (p == 2*N+2)  begin dig = N-1;   ca[4] = 0; end
        else                  begin dig = N-1;   ca[5] = 0; end
      end
      2: begin
        dig = N-1-p; ca[0] = 0; ca[1] = 0; ca[5] = 0; ca[6] = 0;
      end
      default: dig = -1;
    endcase
    an = '1;
    if (dig >= 0) an[dig] = 1'b0;
  endtask

  task automatic model_edge();
    int len;
    if (rst) begin
      m_pos = 0; m_dir = 1; m_cnt = 0; m_mode = int'(mode);
      e_ca = 7'h7F; e_an = '1;
    end else begin
      pattern(m_mode, m_pos, e_ca, e_an);
      if (int'(mode) != m_mode) begin
        m_pos = 0; m_dir = 1; m_cnt = 0; m_mode = int'(mode);
      end else if (en && m_cnt >= int'(period)) begin
        m_cnt = 0;
        if (m_mode == 0 || m_mode == 1) begin
          len   = (m_mode == 0) ? 2*N : 2*N+4;
          m_pos = (m_pos + (cw ? 1 : len-1)) % len;
        end else if (m_mode == 2) begin
          if (m_dir > 0) begin
            if (m_pos == N-1) begin m_pos = N-2; m_dir = -1; end
            else m_pos++;
          end else begin
            if (m_pos == 0) begin m_pos = 1; m_dir = 1; end
            else m_pos--;
          end
        end
      end else if (en) begin
        m_cnt++;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("pos", 32'(pos), 32'(m_pos));
    check("CA",  32'(CA),  32'(e_ca));
    check("AN",  32'(AN),  32'(e_an));
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; cw = 1'b1; mode = 2'd0; period = '0;
    m_pos = 0; m_dir = 1; m_cnt = 0; m_mode = 0; e_ca = 7'h7F; e_an = '1;

    // Reset and first pattern
    step(); step();
    check("rst_CA", 32'(CA), 32'h7F);
    check("rst_AN", 32'(AN), 32'hFF);
    rst = 1'b0;
    step();
    check("rel_pos", 32'(pos), 32'd0);
    check("rel_AN",  32'(AN),  32'h7F);
    check("rel_CA",  32'(CA),  32'b0011100);

    // Square clockwise, one step per clock
    en = 1'b1;
    repeat (8) step();
    check("sq_pos8", 32'(pos), 32'd8);
    step();
    check("sq8_AN", 32'(AN), 32'hFE);
    check("sq8_CA", 32'(CA), 32'b0100011);
    repeat (9) step();

    // Square counter-clockwise from reset, then reverse mid-run
    rst = 1'b1; step(); rst = 1'b0; cw = 1'b0;
    step();
    check("ccw_pos15", 32'(pos), 32'd15);
    step();
    check("ccw_AN", 32'(AN), 32'h7F);
    check("ccw_CA", 32'(CA), 32'b0100011);
    for (int i = 0; i < 40 && m_pos != 12; i++) step();
    check("reach12", 32'(pos), 32'd12);
    cw = 1'b1;
    step();
    check("rev_pos13", 32'(pos), 32'd13);

    // Chase with a 3-clock step, long enough to wrap
    mode = 2'd1; period = 25'd2;
    step();
    check("chase_start", 32'(pos), 32'd0);
    repeat (70) step();

    // Bounce, including a freeze at pos 5
    mode = 2'd2; period = '0;
    repeat (17) step();
    for (int i = 0; i < 40 && m_pos != 5; i++) step();
    check("reach5", 32'(pos), 32'd5);
    en = 1'b0;
    repeat (4) step();
    check("frozen5", 32'(pos), 32'd5);
    en = 1'b1;
    repeat (10) step();

    // Mode switch mid-walk, then reset mid-walk
    mode = 2'd0; cw = 1'b1;
    step();
    for (int i = 0; i < 40 && m_pos != 9; i++) step();
    mode = 2'd1;
    step();
    check("msw_pos0", 32'(pos), 32'd0);
    step();
    check("msw_CA", 32'(CA), 32'b1111110);
    check("msw_AN", 32'(AN), 32'h7F);
    for (int i = 0; i < 40 && m_pos != 4; i++) step();
    rst = 1'b1;
    step();
    check("mrst_CA",  32'(CA),  32'h7F);
    check("mrst_AN",  32'(AN),  32'hFF);
    check("mrst_pos", 32'(pos), 32'd0);
    rst = 1'b0;

    // Blank mode
    mode = 2'd3;
    repeat (5) step();
    check("blank_AN", 32'(AN), 32'hFF);

    // Randomized mix of all inputs
    for (int i = 0; i < 800; i++) begin
      en = ($urandom_range(0, 9) != 0);
      cw = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 40) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 30) == 0) period = DIV_W'($urandom_range(0, 3));
      rst = ($urandom_range(0, 150) == 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
